// File: rtl/bit_pattern_scan_ctrl_if.sv
// Handshake bundle between the host command logic and the bit-pattern scan sequencer.
interface bit_pattern_scan_ctrl_if #(
    parameter int unsigned NOB_WIDTH = 2
);
    logic                 start;
    logic                 abort;
    logic [NOB_WIDTH:0]   b_idx;
    logic                 put_global_array;
    logic                 dp_rst;
    logic                 busy;
    logic                 done;
    logic [NOB_WIDTH:0]   blk_cnt;

    modport master (
        output start, abort,
        input  b_idx, put_global_array, dp_rst, busy, done, blk_cnt
    );

    modport slave (
        input  start, abort,
        output b_idx, put_global_array, dp_rst, busy, done, blk_cnt
    );
endinterface

// File: rtl/bit_pattern_scan_ctrl.sv
// Sequencer for the bit-pattern search datapath: clears the global true-page array,
// walks the block index and issues one registered append strobe per block.
module bit_pattern_scan_ctrl #(
    parameter int unsigned NOB       = 3,
    parameter int unsigned NOB_WIDTH = 2,
    parameter int unsigned PIPE_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    bit_pattern_scan_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = NOB_WIDTH + 1;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_STROBE,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   b_idx_q, b_idx_d;
    logic [IDX_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               put_q, put_d;
    logic               dp_rst_q, dp_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State and registered outputs; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            b_idx_q   <= '0;
            blk_cnt_q <= '0;
            cnt_q     <= '0;
            put_q     <= 1'b0;
            dp_rst_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_idx_q   <= b_idx_d;
            blk_cnt_q <= blk_cnt_d;
            cnt_q     <= cnt_d;
            put_q     <= put_d;
            dp_rst_q  <= dp_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state plus next output values, so outputs line up with the state they belong to.
    always_comb begin
        state_d   = state_q;
        b_idx_d   = b_idx_q;
        blk_cnt_d = blk_cnt_q;
        cnt_d     = cnt_q;
        put_d     = 1'b0;
        dp_rst_d  = 1'b1;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d   = S_CLEAR;
                    busy_d    = 1'b1;
                    b_idx_d   = '0;
                    blk_cnt_d = '0;
                    dp_rst_d  = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
                    state_d = S_STROBE;
                    put_d   = 1'b1;
                end
            end
            S_STROBE: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                blk_cnt_d = blk_cnt_q + IDX_W'(1);
                if (blk_cnt_q == IDX_W'(NOB - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_WAIT;
                    b_idx_d = b_idx_q + IDX_W'(1);
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                b_idx_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel overrides everything outside IDLE; a done already registered still shows.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            b_idx_d   = '0;
            blk_cnt_d = '0;
            cnt_d     = '0;
            put_d     = 1'b0;
            dp_rst_d  = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    assign bus.b_idx            = b_idx_q;
    assign bus.blk_cnt          = blk_cnt_q;
    assign bus.put_global_array = put_q;
    assign bus.dp_rst           = dp_rst_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
endmodule

// File: tb/tb_bit_pattern_scan_ctrl.sv
// Bench for bit_pattern_scan_ctrl: randomized host stimulus checked cycle by cycle
// against a schedule computed from the block/latency arithmetic.
module tb_bit_pattern_scan_ctrl;
    localparam int          NOB       = 3;
    localparam int unsigned NOB_WIDTH = 2;
    localparam logic [9:0]  RST_V     = 10'b0100_000_000;
    localparam logic [9:0]  IDLE_FULL = 10'b0100_000_011;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    bit_pattern_scan_ctrl_if #(.NOB_WIDTH(NOB_WIDTH)) bus2 ();
    bit_pattern_scan_ctrl_if #(.NOB_WIDTH(NOB_WIDTH)) bus3 ();

    bit_pattern_scan_ctrl #(.NOB(NOB), .NOB_WIDTH(NOB_WIDTH), .PIPE_LAT(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    bit_pattern_scan_ctrl #(.NOB(NOB), .NOB_WIDTH(NOB_WIDTH), .PIPE_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {busy, dp_rst, put, done, b_idx, blk_cnt}
    logic [9:0] obs2, obs3;
    assign obs2 = {bus2.busy, bus2.dp_rst, bus2.put_global_array, bus2.done, bus2.b_idx, bus2.blk_cnt};
    assign obs3 = {bus3.busy, bus3.dp_rst, bus3.put_global_array, bus3.done, bus3.b_idx, bus3.blk_cnt};

    // Stand-in datapath: records which block index each strobe appended.
    int log_q[$];
    always @(negedge bus2.dp_rst) log_q.delete();
    always @(posedge bus2.put_global_array) log_q.push_back(int'(bus2.b_idx));

    // Expected outputs k cycles after start was sampled, from the block schedule.
    function automatic void model(input int k, input int lat, output logic [9:0] e, output logic [9:0] m);
        int total, j, blk, ph;
        total = NOB * (lat + 2) + 2;
        m = 10'h3FF;
        if (k == 1) begin
            e = 10'b1000_000_000;
        end else if (k < total) begin
            j   = k - 2;
            blk = j / (lat + 2);
            ph  = j % (lat + 2);
            e   = {1'b1, 1'b1, (ph == lat), 1'b0, 3'(blk), 3'(blk)};
        end else if (k == total) begin
            e = {1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'(NOB)};
            m = 10'b1111_000_111;
        end else begin
            e = IDLE_FULL;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs2 !== RST_V) begin
            failures++;
            $display("FAIL reset_async2 got=%b exp=%b", obs2, RST_V);
        end
        checks++;
        if (obs3 !== RST_V) begin
            failures++;
            $display("FAIL reset_async3 got=%b exp=%b", obs3, RST_V);
        end
        tick();
        tick();
        checks++;
        if (obs2 !== RST_V) begin
            failures++;
            $display("FAIL reset_held got=%b exp=%b", obs2, RST_V);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic(input bit repulse);
        logic [9:0] e, m;
        int total;
        total = NOB * 4 + 2;
        repeat ($urandom_range(0, 3)) tick();
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int k = 1; k <= total + 1; k++) begin
            model(k, 2, e, m);
            checks++;
            if ((obs2 & m) !== (e & m)) begin
                failures++;
                $display("FAIL basic k=%0d repulse=%0d got=%b exp=%b", k, repulse, obs2, e);
            end
            if (repulse && k < total)
                bus2.start = (k == 5 || k == 9) ? 1'b1 : 1'($urandom_range(0, 1));
            else
                bus2.start = 1'b0;
            if (k <= total) tick();
        end
        bus2.start = 1'b0;
        checks++;
        if (log_q.size() != 3 || log_q[0] != 0 || log_q[1] != 1 || log_q[2] != 2) begin
            failures++;
            $display("FAIL append_log size=%0d exp 3 entries 0,1,2", log_q.size());
        end
    endtask

    task automatic test_start_abort_idle();
        bus2.start = 1'b1;
        bus2.abort = 1'b1;
        tick();
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs2 !== IDLE_FULL) begin
                failures++;
                $display("FAIL start_abort_idle i=%0d got=%b exp=%b", i, obs2, IDLE_FULL);
            end
            tick();
        end
    endtask

    task automatic test_abort(input int a);
        logic [9:0] e, m;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int k = 1; k <= a; k++) begin
            model(k, 2, e, m);
            checks++;
            if ((obs2 & m) !== (e & m)) begin
                failures++;
                $display("FAIL abort_pre a=%0d k=%0d got=%b exp=%b", a, k, obs2, e);
            end
            if (k == a) bus2.abort = 1'b1;
            tick();
        end
        bus2.abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs2 !== RST_V) begin
                failures++;
                $display("FAIL abort_post a=%0d i=%0d got=%b exp=%b", a, i, obs2, RST_V);
            end
            tick();
        end
    endtask

    task automatic test_rst_strobe();
        logic [9:0] e, m;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            model(k, 2, e, m);
            checks++;
            if ((obs2 & m) !== (e & m)) begin
                failures++;
                $display("FAIL rst_pre k=%0d got=%b exp=%b", k, obs2, e);
            end
            if (k < 4) tick();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs2 !== RST_V) begin
            failures++;
            $display("FAIL rst_mid_strobe got=%b exp=%b", obs2, RST_V);
        end
        checks++;
        if (obs3 !== RST_V) begin
            failures++;
            $display("FAIL rst_mid_other got=%b exp=%b", obs3, RST_V);
        end
        #1;
        rst = 1'b1;
        tick();
        checks++;
        if (obs2 !== RST_V) begin
            failures++;
            $display("FAIL rst_after got=%b exp=%b", obs2, RST_V);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e, m;
        int total;
        total = NOB * 5 + 2;
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        for (int k = 1; k <= total + 1; k++) begin
            model(k, 3, e, m);
            checks++;
            if ((obs3 & m) !== (e & m)) begin
                failures++;
                $display("FAIL b2b_first k=%0d got=%b exp=%b", k, obs3, e);
            end
            bus3.start = (k == total + 1);
            tick();
        end
        bus3.start = 1'b0;
        for (int k = 1; k <= total + 1; k++) begin
            model(k, 3, e, m);
            checks++;
            if ((obs3 & m) !== (e & m)) begin
                failures++;
                $display("FAIL b2b_second k=%0d got=%b exp=%b", k, obs3, e);
            end
            if (k <= total) tick();
        end
    endtask

    initial begin
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        bus3.start = 1'b0;
        bus3.abort = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_start_abort_idle();
        test_abort(6);
        test_basic(1'b0);
        test_abort(int'($urandom_range(1, 14)));
        test_basic(1'b1);
        test_abort(14);
        test_rst_strobe();
        test_basic(1'b0);
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
